regfile_2r1w: RTL



---
 rtl/regfile_2r1w_if.sv | 30 +++
 rtl/regfile_2r1w.sv | 87 ++++++++
 2 files changed

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the two-read/one-write register file: one write port and
// two independent read ports. The register file takes the slave view.
interface regfile_2r1w_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic             RdEn0;
  logic [AW-1:0]    RdAddr0;
  logic [WIDTH-1:0] RdData0;
  logic             RdEn1;
  logic [AW-1:0]    RdAddr1;
  logic [WIDTH-1:0] RdData1;

  modport master (
    output WrEn, WrAddr, WrData,
    output RdEn0, RdAddr0,
    output RdEn1, RdAddr1,
    input  RdData0, RdData1
  );

  modport slave (
    input  WrEn, WrAddr, WrData,
    input  RdEn0, RdAddr0,
    input  RdEn1, RdAddr1,
    output RdData0, RdData1
  );
endinterface

// File: rtl/regfile_2r1w.sv
// General-purpose operand store: DEPTH words of WIDTH bits, one write port,
// two independent read ports with one cycle of registered read latency.
// Each word is a bank of enable flops (reset zero > write data > hold).
// Optional hard-wired zero word 0 and optional write-first bypass.
module regfile_2r1w #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic           CK,
  input logic           RstN,
  regfile_2r1w_if.slave bus
);

  // Addresses at or above DEPTH name no storage; AW may cover more than DEPTH.
  function automatic logic addr_valid(input logic [AW-1:0] addr);
    return (32'(addr) < DEPTH);
  endfunction

  logic [WIDTH-1:0] words [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] rd_next0;
  logic [WIDTH-1:0] rd_next1;
  logic [WIDTH-1:0] rd_data0_p1;
  logic [WIDTH-1:0] rd_data1_p1;

  // A write only takes effect on real, writable storage. The bypass keys off
  // this same qualifier so an ignored write is never forwarded to a reader.
  assign wr_ok = bus.WrEn && addr_valid(bus.WrAddr) &&
                 !((ZERO_REG != 0) && (bus.WrAddr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic             wr_sel;
    logic [WIDTH-1:0] word_q;

    assign wr_sel = wr_ok && (bus.WrAddr == AW'(i));

    // Word storage: reset clears, write loads, otherwise recirculate.
    always_ff @(posedge CK) begin
      if (!RstN) begin
        word_q <= '0;
      end else if (wr_sel) begin
        word_q <= bus.WrData;
      end
    end

    assign words[i] = word_q;
  end

  // Read selection: out-of-range and the zero register read as 0; a read of
  // the word being written sees the new data when bypass is enabled.
  always_comb begin
    rd_next0 = '0;
    rd_next1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.RdAddr0 == AW'(i)) rd_next0 = words[i];
      if (bus.RdAddr1 == AW'(i)) rd_next1 = words[i];
    end
    if ((ZERO_REG != 0) && (bus.RdAddr0 == '0)) begin
      rd_next0 = '0;
    end else if ((BYPASS != 0) && wr_ok && (bus.WrAddr == bus.RdAddr0)) begin
      rd_next0 = bus.WrData;
    end
    if ((ZERO_REG != 0) && (bus.RdAddr1 == '0)) begin
      rd_next1 = '0;
    end else if ((BYPASS != 0) && wr_ok && (bus.WrAddr == bus.RdAddr1)) begin
      rd_next1 = bus.WrData;
    end
  end

  // ---- stage p1: registered read data, held while the port is idle ----
  always_ff @(posedge CK) begin
    if (!RstN) begin
      rd_data0_p1 <= '0;
      rd_data1_p1 <= '0;
    end else begin
      if (bus.RdEn0) rd_data0_p1 <= rd_next0;
      if (bus.RdEn1) rd_data1_p1 <= rd_next1;
    end
  end

  assign bus.RdData0 = rd_data0_p1;
  assign bus.RdData1 = rd_data1_p1;

endmodule
